// File: rtl/pwm_bank_pkg.sv
// Shared definitions for the PWM channel bank: mode encodings, default parameters
// and the per-channel phase offset helper used when PWM_BANK_PHASE_STAGGER_EN is defined.
package pwm_bank_pkg;

  localparam int NUM_CH_DEF   = 16;
  localparam int DUTY_W_DEF   = 8;
  localparam int PRESCALE_DEF = 13;

  typedef enum logic {
    PWM_MODE_STATIC = 1'b0,
    PWM_MODE_PWM    = 1'b1
  } pwm_mode_e;

  typedef logic [DUTY_W_DEF-1:0] duty_t;

  // Evenly spreads channel edges across one period.
  function automatic int stagger_offset(input int ch, input int num_ch, input int duty_w);
    int period;
    period = 1 << duty_w;
    return (ch * (period / num_ch)) % period;
  endfunction

endpackage

// File: rtl/pwm_bank_channel.sv
// One PWM channel: double-buffered duty (shadow -> active on the period boundary)
// and the registered compare/output mux.
module pwm_bank_channel
  import pwm_bank_pkg::*;
#(
  parameter int DUTY_W = DUTY_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              out_en,
  input  logic              pwm_en,
  input  logic              wr_en,
  input  logic [DUTY_W-1:0] wr_data,
  input  logic              boundary,
  input  logic [DUTY_W-1:0] cnt_i,
  output logic              pwm_out
);

  logic [DUTY_W-1:0] shadow_q, shadow_d;
  logic [DUTY_W-1:0] active_q, active_d;
  logic              pwm_q, pwm_d;

  function automatic logic pwm_level(input logic [DUTY_W-1:0] cnt,
                                     input logic [DUTY_W-1:0] duty);
    if (&duty) return 1'b1;
    return (cnt < duty);
  endfunction

  always_comb begin
    shadow_d = wr_en ? wr_data : shadow_q;
    // A write landing on the boundary goes straight into the coming period.
    active_d = boundary ? shadow_d : active_q;

    pwm_d = 1'b0;
    if (ena && out_en) begin
      if (pwm_mode_e'(pwm_en) == PWM_MODE_STATIC) pwm_d = 1'b1;
      else                                         pwm_d = pwm_level(cnt_i, active_q);
    end
  end

  // Stage boundary: duty registers and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      active_q <= '0;
      pwm_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      pwm_q    <= pwm_d;
    end
  end

  assign pwm_out = pwm_q;

endmodule

// File: rtl/pwm_channel_bank.sv
// N-channel PWM bank: shared prescaler and period counter, boundary detect and
// duty write decode. Optional PWM_BANK_PHASE_STAGGER_EN spreads channel phases.
module pwm_channel_bank
  import pwm_bank_pkg::*;
#(
  parameter int NUM_CH   = NUM_CH_DEF,
  parameter int DUTY_W   = DUTY_W_DEF,
  parameter int PRESCALE = PRESCALE_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ena,
  input  logic [NUM_CH-1:0]         out_en,
  input  logic [NUM_CH-1:0]         pwm_en,
  input  logic                      duty_wr,
  input  logic [$clog2(NUM_CH):0]   duty_wr_ch,
  input  logic [DUTY_W-1:0]         duty_wr_data,
  output logic [NUM_CH-1:0]         pwm_out,
  output logic                      period_start
);

  localparam int PW  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int CHW = $clog2(NUM_CH) + 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0]     presc_q, presc_d;
  logic [DUTY_W-1:0] cnt_q, cnt_d;
  logic              period_start_q, period_start_d;
  logic              tick;
  logic              boundary;

  always_comb begin
    tick     = (presc_q == PRESC_LAST);
    boundary = ena && tick && (&cnt_q);

    presc_d = presc_q;
    cnt_d   = cnt_q;
    if (!ena) begin
      presc_d = '0;
      cnt_d   = '0;
    end else if (tick) begin
      presc_d = '0;
      cnt_d   = cnt_q + DUTY_W'(1);
    end else begin
      presc_d = presc_q + PW'(1);
    end

    period_start_d = boundary;
  end

  // Stage boundary: timebase registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q        <= '0;
      cnt_q          <= '0;
      period_start_q <= 1'b0;
    end else begin
      presc_q        <= presc_d;
      cnt_q          <= cnt_d;
      period_start_q <= period_start_d;
    end
  end

  assign period_start = period_start_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam logic [CHW-1:0] IDX = CHW'(i);
    logic [DUTY_W-1:0] cnt_i;
    logic              wr_sel;

`ifdef PWM_BANK_PHASE_STAGGER_EN
    localparam logic [DUTY_W-1:0] OFS = DUTY_W'(stagger_offset(i, NUM_CH, DUTY_W));
    assign cnt_i = cnt_q + OFS;
`else
    assign cnt_i = cnt_q;
`endif

    // Out-of-range indices never match any channel.
    assign wr_sel = duty_wr && (duty_wr_ch == IDX);

    pwm_bank_channel #(
      .DUTY_W(DUTY_W)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .out_en  (out_en[i]),
      .pwm_en  (pwm_en[i]),
      .wr_en   (wr_sel),
      .wr_data (duty_wr_data),
      .boundary(boundary),
      .cnt_i   (cnt_i),
      .pwm_out (pwm_out[i])
    );
  end

endmodule

// File: tb/tb_pwm_channel_bank.sv
// Directed bench for pwm_channel_bank at NUM_CH=16, DUTY_W=8, PRESCALE=13 (default build).
module tb_pwm_channel_bank;

  localparam int NUM_CH   = 16;
  localparam int DUTY_W   = 8;
  localparam int PRESCALE = 13;
  localparam int PERIOD   = 256 * PRESCALE;

  logic              clk;
  logic              rst_n;
  logic              ena;
  logic [NUM_CH-1:0] out_en;
  logic [NUM_CH-1:0] pwm_en;
  logic              duty_wr;
  logic [4:0]        duty_wr_ch;
  logic [DUTY_W-1:0] duty_wr_data;
  logic [NUM_CH-1:0] pwm_out;
  logic              period_start;

  int checks = 0;
  int errors = 0;

  pwm_channel_bank #(
    .NUM_CH  (NUM_CH),
    .DUTY_W  (DUTY_W),
    .PRESCALE(PRESCALE)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .out_en      (out_en),
    .pwm_en      (pwm_en),
    .duty_wr     (duty_wr),
    .duty_wr_ch  (duty_wr_ch),
    .duty_wr_data(duty_wr_data),
    .pwm_out     (pwm_out),
    .period_start(period_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ena;
    logic [15:0] out_en;
    logic [15:0] pwm_en;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic write_duty(input int ch, input logic [7:0] data);
    duty_wr      = 1'b1;
    duty_wr_ch   = 5'(ch);
    duty_wr_data = data;
    @(negedge clk);
    duty_wr      = 1'b0;
  endtask

  // Advances to the next negedge with period_start high; counts ones on channel ch on the way.
  task automatic wait_start(input int ch, output int ones);
    int n;
    n    = 0;
    ones = 0;
    while (n < 2 * PERIOD + 100) begin
      @(negedge clk);
      n++;
      if (pwm_out[ch]) ones++;
      if (period_start) break;
    end
    check("wait_period_start", {31'd0, period_start}, 32'd1);
  endtask

  // Called at a period_start negedge; returns high and low run lengths of channel ch.
  task automatic measure(input int ch, output int hi, output int lo);
    @(negedge clk);
    hi = 0;
    lo = 0;
    while (pwm_out[ch] && hi < PERIOD + 100) begin
      hi++;
      @(negedge clk);
    end
    while (!pwm_out[ch] && lo < PERIOD + 100) begin
      lo++;
      @(negedge clk);
    end
  endtask

  initial begin
    int hi, lo, ones, cnt, n;

    vecs[0] = '{1'b1, 16'h0001, 16'h0000, 16'h0001};
    vecs[1] = '{1'b1, 16'hFFFF, 16'h0000, 16'hFFFF};
    vecs[2] = '{1'b1, 16'hFFFF, 16'hFFFF, 16'h0000};
    vecs[3] = '{1'b1, 16'hA5A5, 16'h0F0F, 16'hA0A0};
    vecs[4] = '{1'b0, 16'hFFFF, 16'h0000, 16'h0000};
    vecs[5] = '{1'b1, 16'h8001, 16'h0001, 16'h8000};
    vecs[6] = '{1'b1, 16'h0000, 16'h0000, 16'h0000};
    vecs[7] = '{1'b1, 16'h0008, 16'h0000, 16'h0008};

    rst_n        = 1'b0;
    ena          = 1'b0;
    out_en       = '0;
    pwm_en       = '0;
    duty_wr      = 1'b0;
    duty_wr_ch   = '0;
    duty_wr_data = '0;
    repeat (3) @(negedge clk);
    check("reset_pwm_out", 32'(pwm_out), 32'd0);
    check("reset_period_start", {31'd0, period_start}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Static/enable/ena combinations with every active duty still zero.
    for (int i = 0; i < 8; i++) begin
      ena    = vecs[i].ena;
      out_en = vecs[i].out_en;
      pwm_en = vecs[i].pwm_en;
      @(negedge clk);
      check($sformatf("vec%0d_pwm_out", i), 32'(pwm_out), 32'(vecs[i].exp));
    end

    ena    = 1'b1;
    out_en = 16'h0069;
    pwm_en = 16'h0069;
    write_duty(3, 8'h80);
    write_duty(0, 8'h20);

    // 50 % duty on ch3.
    wait_start(3, ones);
    measure(3, hi, lo);
    check("ch3_0x80_high", 32'(hi), 32'd1664);
    check("ch3_0x80_low", 32'(lo), 32'd1664);

    // Duty 0x00 stays low a full period, 0xFF stays high across a boundary.
    write_duty(3, 8'h00);
    wait_start(3, ones);
    ones = 0;
    repeat (PERIOD) begin
      @(negedge clk);
      if (pwm_out[3]) ones++;
    end
    check("ch3_0x00_ones", 32'(ones), 32'd0);
    write_duty(3, 8'hFF);
    wait_start(3, ones);
    cnt = 0;
    repeat (PERIOD + 72) begin
      @(negedge clk);
      if (!pwm_out[3]) cnt++;
    end
    check("ch3_0xFF_zeros", 32'(cnt), 32'd0);

    // Mid-period write holds until the boundary; index 16 is ignored.
    write_duty(5, 8'h40);
    wait_start(5, ones);
    repeat (1000) @(negedge clk);
    duty_wr      = 1'b1;
    duty_wr_ch   = 5'd5;
    duty_wr_data = 8'hC0;
    @(negedge clk);
    duty_wr_ch   = 5'd16;
    duty_wr_data = 8'h11;
    @(negedge clk);
    duty_wr      = 1'b0;
    wait_start(5, ones);
    check("ch5_old_duty_held", 32'(ones), 32'd0);
    measure(5, hi, lo);
    check("ch5_0xC0_high", 32'(hi), 32'd2496);
    check("ch5_0xC0_low", 32'(lo), 32'd832);
    wait_start(0, ones);
    measure(0, hi, lo);
    check("ch0_after_idx16_high", 32'(hi), 32'd416);
    check("ch0_after_idx16_low", 32'(lo), 32'd2912);

    // Write coincident with the boundary cycle.
    wait_start(6, ones);
    repeat (PERIOD - 1) @(negedge clk);
    duty_wr      = 1'b1;
    duty_wr_ch   = 5'd6;
    duty_wr_data = 8'h40;
    @(negedge clk);
    duty_wr      = 1'b0;
    check("boundary_write_period_start", {31'd0, period_start}, 32'd1);
    measure(6, hi, lo);
    check("ch6_boundary_write_high", 32'(hi), 32'd832);
    check("ch6_boundary_write_low", 32'(lo), 32'd2496);

    // Asynchronous reset mid-run.
    pwm_en[3] = 1'b0;
    @(negedge clk);
    check("pre_reset_ch3_static", {31'd0, pwm_out[3]}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_pwm_out", 32'(pwm_out), 32'd0);
    check("async_reset_period_start", {31'd0, period_start}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (n < 2 * PERIOD) begin
      @(negedge clk);
      n++;
      if (n == 2) check("post_reset_duties_cleared", 32'(pwm_out), 32'h0008);
      if (period_start) break;
    end
    check("post_reset_first_period_start", 32'(n), 32'(PERIOD));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
